// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
// Instruction fetch front end for the multi-cycle core. It issues word-aligned
// requests to a synchronous instruction memory that answers one cycle later,
// and buffers the returned words in a small FIFO. The FIFO head is presented
// as `command`; the core pops it with `done`. A `redirect` flushes the queue
// and restarts fetch at a new PC.
//
// A FIFO slot is reserved for every outstanding response. Because of this, a
// request is only issued when the queued words plus the word in flight leave
// room. The FIFO therefore cannot overflow, and no backpressure on the memory
// side is needed.

module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  output logic [31:0]              mem_addr,
  output logic                     mem_req,
  input  logic [31:0]              mem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     done,
  output logic [31:0]              command,
  output logic                     cmd_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] occ;
  logic          inflight;
  logic          squash;
  logic [31:0]   fifo_mem [DEPTH];

  logic [CW:0]   reserved;
  logic          room;
  logic          push;
  logic          pop;

  // Decide whether a request may go out this cycle. Also decide which
  // queue operations take effect on the coming edge.
  // A pop in the same cycle is deliberately not counted as free space.
  always_comb begin
    reserved = {1'b0, occ} + (CW+1)'(inflight);
    room     = reserved < (CW+1)'(DEPTH);
    mem_req  = run & ~redirect & ~reset & room;
    push     = inflight & ~squash & ~redirect;
    pop      = done & cmd_valid & ~redirect;
  end

  assign mem_addr  = fetch_pc;
  assign cmd_valid = (occ != '0);
  assign command   = cmd_valid ? fifo_mem[rd_ptr] : NOP;
  assign count     = occ;

  // Capture the returning instruction word into the FIFO storage.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_mem[wr_ptr] <= mem_rdata;
    end
  end

  // Fetch PC, queue pointers/occupancy and response tracking.
  // Redirect outranks fetch, response and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      // No request goes out during a redirect, so nothing new is in flight.
      inflight <= 1'b0;
      squash   <= inflight;
    end else begin
      squash   <= 1'b0;
      inflight <= mem_req;
      if (mem_req) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Testbench for instr_fetch_queue.
// The memory model answers every request one cycle later with the request
// address as the instruction word. A queue-based reference model tracks what
// the fetch stage should hold. It is compared against the DUT on every falling
// edge, and directed scenarios add hand-computed literal checks.

module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        done;
  logic [31:0] command;
  logic        cmd_valid;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .done        (done),
    .command     (command),
    .cmd_valid   (cmd_valid),
    .count       (count)
  );

  // synchronous instruction memory: word = address, garbage when not requested
  always @(posedge clk) mem_rdata <= mem_req ? mem_addr : 32'hBAD0_BAD0;

  // reference model
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_q[$];
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_word = '0;

  function automatic bit m_req();
    return (run === 1'b1) && (redirect !== 1'b1) && (reset !== 1'b1) &&
           (m_q.size() + int'(m_pend) < DEPTH);
  endfunction

  always @(posedge clk) begin : model
    bit req;
    req = m_req();
    if (reset) begin
      m_pc   = RESET_PC;
      m_q.delete();
      m_pend = 1'b0;
    end else if (redirect) begin
      m_q.delete();
      m_pc   = redirect_pc & ~32'h3;
      m_pend = 1'b0;
    end else begin
      if (done && m_q.size() > 0) void'(m_q.pop_front());
      if (m_pend) m_q.push_back(m_pend_word);
      if (req) begin
        m_pend_word = m_pc;
        m_pc        = m_pc + 32'd4;
      end
      m_pend = req;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req",   {31'b0, mem_req},   {31'b0, m_req()});
      check("mem_addr",  mem_addr,           m_pc);
      check("cmd_valid", {31'b0, cmd_valid}, {31'b0, m_q.size() > 0});
      check("command",   command,            (m_q.size() > 0) ? m_q[0] : NOP);
      check("count",     {29'b0, count},     m_q.size());
    end
  end

  task automatic set_in(input bit rs, input bit r, input bit d, input bit rd,
                        input logic [31:0] rpc);
    reset       = rs;
    run         = r;
    done        = d;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  task automatic tick(input bit rs, input bit r, input bit d, input bit rd,
                      input logic [31:0] rpc);
    set_in(rs, r, d, rd, rpc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk_en = 1'b1;

    // reset state
    check("rst_count",     {29'b0, count},     0);
    check("rst_cmd_valid", {31'b0, cmd_valid}, 0);
    check("rst_command",   command,            NOP);
    check("rst_mem_addr",  mem_addr,           RESET_PC);
    check("rst_mem_req",   {31'b0, mem_req},   0);

    // fill: requests 0,4,8,12 then stall with a full queue
    repeat (8) tick(0, 1, 0, 0, 0);
    check("fill_count",    {29'b0, count},   4);
    check("fill_command",  command,          32'h0);
    check("fill_mem_req",  {31'b0, mem_req}, 0);
    check("fill_mem_addr", mem_addr,         32'd16);

    // single pop from a full queue, then refill with address 16
    tick(0, 1, 1, 0, 0);
    check("pop_command",  command,          32'd4);
    check("pop_count",    {29'b0, count},   3);
    check("pop_next_req", {31'b0, mem_req}, 1);
    check("pop_next_addr", mem_addr,        32'd16);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    check("refill_count", {29'b0, count}, 4);
    check("refill_addr",  mem_addr,       32'd20);

    // back-to-back pops deliver one word per cycle: 4, 8, 12, 16
    for (int i = 0; i < 4; i++) begin
      check("drain_command", command, 32'd4 * (i + 1));
      tick(0, 0, 1, 0, 0);
    end
    check("drain_count", {29'b0, count}, 0);

    // done with an empty queue is ignored
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 0);
    check("empty_count",   {29'b0, count},     0);
    check("empty_valid",   {31'b0, cmd_valid}, 0);
    check("empty_command", command,            NOP);

    // redirect while a response is in flight
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 1, 32'h0000_0102);
    check("rd_count", {29'b0, count},     0);
    check("rd_valid", {31'b0, cmd_valid}, 0);
    check("rd_addr",  mem_addr,           32'h100);
    tick(0, 1, 0, 0, 0);
    check("rd_valid_r2", {31'b0, cmd_valid}, 0);
    tick(0, 1, 0, 0, 0);
    check("rd_valid_r3",   {31'b0, cmd_valid}, 1);
    check("rd_command_r3", command,            32'h100);

    // redirect and done together, then PC wrap at the top of memory
    tick(0, 1, 1, 1, 32'hFFFF_FFFF);
    check("rdd_count", {29'b0, count},     0);
    check("rdd_valid", {31'b0, cmd_valid}, 0);
    check("rdd_addr",  mem_addr,           32'hFFFF_FFFC);
    tick(0, 1, 0, 0, 0);
    check("wrap_addr", mem_addr, 32'h0);
    tick(0, 1, 0, 0, 0);
    check("wrap_valid",   {31'b0, cmd_valid}, 1);
    check("wrap_command", command,            32'hFFFF_FFFC);

    // reset while the queue holds three entries
    tick(1, 0, 0, 0, 0);
    repeat (4) tick(0, 1, 0, 0, 0);
    check("mid_count", {29'b0, count}, 3);
    tick(1, 1, 0, 0, 0);
    check("mid_rst_count",   {29'b0, count},     0);
    check("mid_rst_valid",   {31'b0, cmd_valid}, 0);
    check("mid_rst_command", command,            NOP);
    check("mid_rst_addr",    mem_addr,           RESET_PC);
    check("mid_rst_req",     {31'b0, mem_req},   0);
    set_in(0, 1, 0, 0, 0);
    #1;
    check("first_req",      {31'b0, mem_req}, 1);
    check("first_req_addr", mem_addr,         RESET_PC);
    @(posedge clk);
    #1;
    repeat (6) tick(0, 1, 0, 0, 0);
    check("final_count", {29'b0, count}, 4);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage that sits directly upstream of the multi-cycle RISC-V core and supplies its `command` input. It generates word-aligned fetch addresses to a synchronous instruction memory and buffers returned words in a small FIFO. It presents the FIFO head as the next instruction and pops it when the core pulses `done`. A `redirect` input flushes the queue and restarts fetch at a new PC. This input is driven when the core takes a jump or branch.

## Interface

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- run  in  1  fetch enable; when low, no new memory requests are issued
- mem_addr  out  32  fetch byte address, equal to fetch_pc; bits [1:0] are always 0
- mem_req  out  1  fetch request; memory samples `mem_addr` on the edge that ends this cycle
- mem_rdata  in  32  instruction word, valid exactly one cycle after the `mem_req` cycle
- redirect  in  1  flush the queue and restart fetch at `redirect_pc`
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 0
- done  in  1  core finished the current instruction; pops the FIFO head
- command  out  32  FIFO head when `cmd_valid` is high, otherwise 32'h0000_0013 (NOP)
- cmd_valid  out  1  FIFO not empty
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation

State:
- fetch_pc (32)
- rd_ptr/wr_ptr (log2 DEPTH bits each; wrap modulo DEPTH)
- count
- inflight flag (1 = a response is due next cycle)
- squash flag (1 = the due response is discarded)

Request generation (combinational):
- `mem_req = run & ~redirect & ~reset & (count + inflight < DEPTH)`.
- A slot is reserved for every outstanding response, so the FIFO never overflows.
- A pop in the same cycle gives no credit.

On each edge where `mem_req` is high:
- fetch_pc <= fetch_pc + 4. Wraps modulo 2^32, so 32'hFFFF_FFFC goes to 0.
- inflight <= 1.

When no request is issued, inflight <= 0.

Response: when inflight is high and squash is low, `mem_rdata` is written at wr_ptr and wr_ptr increments.

Pop: when `done & cmd_valid`, rd_ptr increments. A `done` while the FIFO is empty is ignored.

Occupancy:
- Push and pop in the same cycle leave count unchanged.
- count is never greater than DEPTH and never less than 0.

Redirect has priority over everything. On the edge where `redirect` is high:
- rd_ptr, wr_ptr and count go to 0.
- fetch_pc <= {redirect_pc[31:2], 2'b00}.
- squash <= inflight, so a response already in flight is dropped.
- A `done` or response in that same cycle is ignored.

`run` low:
- Outstanding responses are still accepted.
- Queued entries remain and can still be popped.

Reset values:
- fetch_pc = RESET_PC, pointers = 0, count = 0, inflight = 0, squash = 0.
- Outputs: `mem_req` = 0, `mem_addr` = RESET_PC, `cmd_valid` = 0, `command` = 32'h0000_0013.

Reset mid-operation discards all queued and in-flight words.

## Timing

- Fetch-to-valid latency: cycle N has `mem_req`=1; `mem_rdata` arrives in N+1; `cmd_valid` is high in N+2.
- Steady state: one request per cycle while there is room.
- Refill after redirect: the redirect is in cycle R; the first request for the new PC is in R+1; `cmd_valid` is high in R+3.
- `command`, `cmd_valid` and `count` are registered state (command is a mux of state only); no input reaches them combinationally.
- A `done` pulse lasts one cycle. The head changes on the edge that ends the `done` cycle.
- With back-to-back `done` pulses and a full FIFO, one instruction is delivered per cycle.

## Test plan

- Reset then run=1, memory returns word = address: requests go to 0, 4, 8, 12, then `mem_req` drops. count = 4, `command` = 0. No further requests occur until `done`.
- Full FIFO, single `done`: `command` goes 0 → 4, count 4 → 3. The next request is to address 16 and pushes 16, after which count = 4 again.
- `done` with an empty FIFO (run=0 after reset): count stays 0, `cmd_valid` = 0, `command` = 32'h13.
- Redirect to 32'h0000_0102 while a response is in flight:
  - The in-flight word is dropped and count = 0.
  - The next request address is 32'h100 (bits [1:0] forced to 0).
  - `cmd_valid` rises 3 cycles after the redirect with `command` = 32'h100.
- Redirect and `done` in the same cycle: redirect wins and count = 0. fetch_pc = 0xFFFF_FFFC followed by a request wraps `mem_addr` to 0.
- Assert `reset` for one cycle after the FIFO holds 3 entries: all outputs return to their reset values. The first request after release goes to RESET_PC.
